// File: rtl/mac_pkg.sv
// Shared types and constants for the MAC job sequencer.
// State encoding, MAC load-mode values and the N*N counter width helper.
package mac_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RST    = 3'd1,
    ST_LOAD_W = 3'd2,
    ST_LOAD_X = 3'd3,
    ST_DRAIN  = 3'd4,
    ST_DONE   = 3'd5
  } state_e;

  localparam logic MAC_MODE_W = 1'b1;
  localparam logic MAC_MODE_X = 1'b0;

  // Width able to hold the values 0..n*n inclusive.
  function automatic int cnt_w(input int n);
    return $clog2(n * n + 1);
  endfunction

endpackage

// File: rtl/mac_seq_cnt.sv
// Loadable up-counter with a terminal-count flag (count equals term_i).
// Load has priority over increment; en_i freezes the count entirely.
module mac_seq_cnt #(
  parameter int CW = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en_i,
  input  logic          load_i,
  input  logic [CW-1:0] load_val_i,
  input  logic          inc_i,
  input  logic [CW-1:0] term_i,
  output logic          tc_o
);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (inc_i) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (en_i) begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == term_i);

endmodule

// File: rtl/mac_seq.sv
// Job sequencer feeding the systolic MAC load port: address reset, weight and
// input streaming from the host handshake, then result collection with timeout.
module mac_seq
  import mac_pkg::*;
#(
  parameter int W    = 8,
  parameter int N    = 2,
  parameter int TO_W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ena,
  input  logic         start_i,
  input  logic         reuse_w_i,
  input  logic         in_v_i,
  input  logic [W-1:0] in_data_i,
  output logic         in_rdy_o,
  output logic         mac_data_v_o,
  output logic         mac_data_mode_o,
  output logic         mac_data_rst_o,
  output logic [W-1:0] mac_data_o,
  input  logic         mac_result_v_i,
  input  logic [W-1:0] mac_result_i,
  output logic         out_v_o,
  output logic [W-1:0] out_data_o,
  output logic         busy_o,
  output logic         done_o,
  output logic         err_to_o
);

  localparam int CW = cnt_w(N);
  localparam logic [CW-1:0] NN_M1 = CW'(N * N - 1);
  // Fires on the idle cycle that would take the timeout count to all-ones.
  localparam logic [TO_W-1:0] TO_TERM = {{(TO_W - 1){1'b1}}, 1'b0};

  state_e state_q, state_d;
  logic reuse_q, reuse_d;
  logic err_q, err_d;
  logic res_full_q, res_full_d;
  logic mac_v_q, mac_v_d;
  logic mode_q, mode_d;
  logic mrst_q, mrst_d;
  logic [W-1:0] mdata_q, mdata_d;
  logic out_v_q, out_v_d;
  logic [W-1:0] out_data_q, out_data_d;
  logic busy_q, busy_d;
  logic done_q, done_d;

  logic loading, accept, start_acc, counted;
  logic byte_tc, res_tc, to_tc;
  logic byte_load, res_inc, to_load, to_inc;

  assign loading   = (state_q == ST_LOAD_W) || (state_q == ST_LOAD_X);
  assign in_rdy_o  = ena && loading;
  assign accept    = in_v_i && in_rdy_o;
  assign start_acc = (state_q == ST_IDLE) && start_i;
  assign counted   = mac_result_v_i && (loading || (state_q == ST_DRAIN));
  assign byte_load = start_acc || (accept && byte_tc);
  assign res_inc   = counted && !res_full_q;
  assign to_load   = (state_q != ST_DRAIN) || mac_result_v_i;
  assign to_inc    = (state_q == ST_DRAIN);

  mac_seq_cnt #(.CW(CW)) u_byte_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .en_i       (ena),
    .load_i     (byte_load),
    .load_val_i ('0),
    .inc_i      (accept),
    .term_i     (NN_M1),
    .tc_o       (byte_tc)
  );

  mac_seq_cnt #(.CW(CW)) u_res_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .en_i       (ena),
    .load_i     (start_acc),
    .load_val_i ('0),
    .inc_i      (res_inc),
    .term_i     (NN_M1),
    .tc_o       (res_tc)
  );

  mac_seq_cnt #(.CW(TO_W)) u_to_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .en_i       (ena),
    .load_i     (to_load),
    .load_val_i ('0),
    .inc_i      (to_inc),
    .term_i     (TO_TERM),
    .tc_o       (to_tc)
  );

  // Results can complete during the load phases; the flag lets DRAIN exit at once.
  assign res_full_d = start_acc ? 1'b0 : (res_full_q || (res_inc && res_tc));

  always_comb begin
    state_d = state_q;
    reuse_d = reuse_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d = ST_RST;
          reuse_d = reuse_w_i;
          err_d   = 1'b0;
        end
      end
      ST_RST:    state_d = reuse_q ? ST_LOAD_X : ST_LOAD_W;
      ST_LOAD_W: if (accept && byte_tc) state_d = ST_LOAD_X;
      ST_LOAD_X: if (accept && byte_tc) state_d = ST_DRAIN;
      ST_DRAIN: begin
        if (res_full_q || (counted && res_tc)) begin
          state_d = ST_DONE;
        end else if (!mac_result_v_i && to_tc) begin
          state_d = ST_DONE;
          err_d   = 1'b1;
        end
      end
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase

    mac_v_d    = accept;
    mdata_d    = accept ? in_data_i : mdata_q;
    mode_d     = accept ? ((state_q == ST_LOAD_W) ? MAC_MODE_W : MAC_MODE_X) : mode_q;
    mrst_d     = (state_d == ST_RST);
    busy_d     = (state_d != ST_IDLE);
    done_d     = (state_d == ST_DONE);
    out_v_d    = mac_result_v_i;
    out_data_d = mac_result_v_i ? mac_result_i : out_data_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      reuse_q    <= 1'b0;
      err_q      <= 1'b0;
      res_full_q <= 1'b0;
      mac_v_q    <= 1'b0;
      mode_q     <= 1'b0;
      mrst_q     <= 1'b0;
      mdata_q    <= '0;
      out_v_q    <= 1'b0;
      out_data_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else if (ena) begin
      state_q    <= state_d;
      reuse_q    <= reuse_d;
      err_q      <= err_d;
      res_full_q <= res_full_d;
      mac_v_q    <= mac_v_d;
      mode_q     <= mode_d;
      mrst_q     <= mrst_d;
      mdata_q    <= mdata_d;
      out_v_q    <= out_v_d;
      out_data_q <= out_data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign mac_data_v_o    = mac_v_q;
  assign mac_data_mode_o = mode_q;
  assign mac_data_rst_o  = mrst_q;
  assign mac_data_o      = mdata_q;
  assign out_v_o         = out_v_q;
  assign out_data_o      = out_data_q;
  assign busy_o          = busy_q;
  assign done_o          = done_q;
  assign err_to_o        = err_q;

endmodule

// File: tb/tb_mac_seq.sv
// Directed bench for mac_seq: full job, weight reuse, bubbles, timeout,
// mid-job reset and ena stall with an ignored start.
module tb_mac_seq;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         ena = 1'b1;
  logic         start_i = 1'b0;
  logic         reuse_w_i = 1'b0;
  logic         in_v_i = 1'b0;
  logic [W-1:0] in_data_i = '0;
  logic         mac_result_v_i = 1'b0;
  logic [W-1:0] mac_result_i = '0;
  logic         in_rdy_o, mac_data_v_o, mac_data_mode_o, mac_data_rst_o;
  logic [W-1:0] mac_data_o, out_data_o;
  logic         out_v_o, busy_o, done_o, err_to_o;

  int checks = 0;
  int errors = 0;
  int n_rst = 0, n_wbeat = 0, n_xbeat = 0, n_out = 0, n_done = 0;
  logic ena_seen = 1'b0;

  always #5 clk = ~clk;

  mac_seq #(.W(W), .N(2), .TO_W(4)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .ena             (ena),
    .start_i         (start_i),
    .reuse_w_i       (reuse_w_i),
    .in_v_i          (in_v_i),
    .in_data_i       (in_data_i),
    .in_rdy_o        (in_rdy_o),
    .mac_data_v_o    (mac_data_v_o),
    .mac_data_mode_o (mac_data_mode_o),
    .mac_data_rst_o  (mac_data_rst_o),
    .mac_data_o      (mac_data_o),
    .mac_result_v_i  (mac_result_v_i),
    .mac_result_i    (mac_result_i),
    .out_v_o         (out_v_o),
    .out_data_o      (out_data_o),
    .busy_o          (busy_o),
    .done_o          (done_o),
    .err_to_o        (err_to_o)
  );

  // Event counters only count cycles that follow an enabled edge.
  always @(posedge clk) ena_seen = ena;

  always @(negedge clk) begin
    if (ena_seen) begin
      if (mac_data_rst_o) n_rst++;
      if (mac_data_v_o && mac_data_mode_o) n_wbeat++;
      if (mac_data_v_o && !mac_data_mode_o) n_xbeat++;
      if (out_v_o) n_out++;
      if (done_o) n_done++;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input int n, input logic [W-1:0] first);
    for (int i = 0; i < n; i++) begin
      in_v_i    = 1'b1;
      in_data_i = first + W'(i);
      cyc();
    end
    in_v_i = 1'b0;
  endtask

  task automatic results(input int n, input logic [W-1:0] first);
    for (int i = 0; i < n; i++) begin
      mac_result_v_i = 1'b1;
      mac_result_i   = first + W'(i);
      cyc();
    end
    mac_result_v_i = 1'b0;
  endtask

  task automatic begin_job(input logic reuse);
    start_i   = 1'b1;
    reuse_w_i = reuse;
    cyc();
    start_i   = 1'b0;
    reuse_w_i = 1'b0;
    cyc();
  endtask

  task automatic test_reset();
    logic [23:0] v;
    rst_n = 1'b0;
    cyc();
    cyc();
    v = {in_rdy_o, mac_data_v_o, mac_data_mode_o, mac_data_rst_o, mac_data_o,
         out_v_o, out_data_o, busy_o, done_o, err_to_o};
    checks++;
    if (v !== 24'h0) begin
      errors++;
      $display("FAIL reset_outputs got %h want 000000", v);
    end
    rst_n = 1'b1;
    cyc();
    checks++;
    if ({busy_o, in_rdy_o, mac_data_rst_o} !== 3'b000) begin
      errors++;
      $display("FAIL reset_idle got %b want 000", {busy_o, in_rdy_o, mac_data_rst_o});
    end
    $display("reset: done");
  endtask

  task automatic test_full_job();
    int r0, w0, x0, d0;
    logic [W+1:0] got, exp;
    r0 = n_rst; w0 = n_wbeat; x0 = n_xbeat; d0 = n_done;
    start_i = 1'b1;
    cyc();
    start_i = 1'b0;
    checks++;
    if ({mac_data_rst_o, busy_o} !== 2'b11) begin
      errors++;
      $display("FAIL full_rst_pulse got %b want 11", {mac_data_rst_o, busy_o});
    end
    cyc();
    checks++;
    if ({mac_data_rst_o, in_rdy_o} !== 2'b01) begin
      errors++;
      $display("FAIL full_first_load got %b want 01", {mac_data_rst_o, in_rdy_o});
    end
    for (int i = 0; i < 8; i++) begin
      in_v_i    = 1'b1;
      in_data_i = W'(i + 1);
      cyc();
      got = {mac_data_v_o, mac_data_mode_o, mac_data_o};
      exp = {1'b1, (i < 4) ? 1'b1 : 1'b0, W'(i + 1)};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL full_beat%0d got %h want %h", i, got, exp);
      end
    end
    in_v_i = 1'b0;
    checks++;
    if (in_rdy_o !== 1'b0) begin
      errors++;
      $display("FAIL full_drain_rdy got %b want 0", in_rdy_o);
    end
    cyc(); cyc(); cyc();
    for (int j = 0; j < 4; j++) begin
      mac_result_v_i = 1'b1;
      mac_result_i   = 8'hA0 + W'(j);
      cyc();
      checks++;
      if ({out_v_o, out_data_o, done_o} !== {1'b1, 8'hA0 + W'(j), (j == 3) ? 1'b1 : 1'b0}) begin
        errors++;
        $display("FAIL full_result%0d got v=%b d=%h done=%b want v=1 d=%h done=%b",
                 j, out_v_o, out_data_o, done_o, 8'hA0 + W'(j), (j == 3));
      end
    end
    mac_result_v_i = 1'b0;
    cyc();
    checks++;
    if ({done_o, busy_o, err_to_o} !== 3'b000) begin
      errors++;
      $display("FAIL full_end got %b want 000", {done_o, busy_o, err_to_o});
    end
    checks++;
    if ({n_rst - r0, n_wbeat - w0, n_xbeat - x0, n_done - d0} !== {32'd1, 32'd4, 32'd4, 32'd1}) begin
      errors++;
      $display("FAIL full_counts got rst=%0d w=%0d x=%0d done=%0d want 1 4 4 1",
               n_rst - r0, n_wbeat - w0, n_xbeat - x0, n_done - d0);
    end
    $display("full_job: rst=%0d w=%0d x=%0d", n_rst - r0, n_wbeat - w0, n_xbeat - x0);
  endtask

  task automatic test_reuse();
    int w0, x0, d0;
    w0 = n_wbeat; x0 = n_xbeat; d0 = n_done;
    start_i   = 1'b1;
    reuse_w_i = 1'b1;
    cyc();
    start_i   = 1'b0;
    reuse_w_i = 1'b0;
    checks++;
    if (mac_data_rst_o !== 1'b1) begin
      errors++;
      $display("FAIL reuse_rst got %b want 1", mac_data_rst_o);
    end
    cyc();
    feed(4, 8'h11);
    checks++;
    if ({in_rdy_o, mac_data_mode_o, mac_data_o} !== {1'b0, 1'b0, 8'h14}) begin
      errors++;
      $display("FAIL reuse_after_x got rdy=%b mode=%b d=%h want 0 0 14",
               in_rdy_o, mac_data_mode_o, mac_data_o);
    end
    results(4, 8'h50);
    checks++;
    if ({done_o, out_data_o} !== {1'b1, 8'h53}) begin
      errors++;
      $display("FAIL reuse_done got done=%b d=%h want 1 53", done_o, out_data_o);
    end
    cyc();
    checks++;
    if ({n_wbeat - w0, n_xbeat - x0, n_done - d0} !== {32'd0, 32'd4, 32'd1}) begin
      errors++;
      $display("FAIL reuse_counts got w=%0d x=%0d done=%0d want 0 4 1",
               n_wbeat - w0, n_xbeat - x0, n_done - d0);
    end
    $display("reuse: w=%0d x=%0d", n_wbeat - w0, n_xbeat - x0);
  endtask

  task automatic test_bubbles();
    int w0, x0, d0;
    logic drv;
    w0 = n_wbeat; x0 = n_xbeat; d0 = n_done;
    begin_job(1'b0);
    for (int i = 0; i < 16; i++) begin
      drv       = (i % 2 == 0);
      in_v_i    = drv;
      in_data_i = 8'h20 + W'(i / 2);
      cyc();
      checks++;
      if (mac_data_v_o !== drv) begin
        errors++;
        $display("FAIL bubble_v%0d got %b want %b", i, mac_data_v_o, drv);
      end
    end
    in_v_i = 1'b0;
    checks++;
    if ({in_rdy_o, mac_data_o} !== {1'b0, 8'h27}) begin
      errors++;
      $display("FAIL bubble_drain got rdy=%b d=%h want 0 27", in_rdy_o, mac_data_o);
    end
    results(4, 8'h60);
    checks++;
    if (done_o !== 1'b1) begin
      errors++;
      $display("FAIL bubble_done got %b want 1", done_o);
    end
    cyc();
    checks++;
    if ({n_wbeat - w0, n_xbeat - x0, n_done - d0} !== {32'd4, 32'd4, 32'd1}) begin
      errors++;
      $display("FAIL bubble_counts got w=%0d x=%0d done=%0d want 4 4 1",
               n_wbeat - w0, n_xbeat - x0, n_done - d0);
    end
    $display("bubbles: w=%0d x=%0d", n_wbeat - w0, n_xbeat - x0);
  endtask

  task automatic test_timeout();
    logic early;
    early = 1'b0;
    begin_job(1'b0);
    feed(8, 8'h01);
    results(2, 8'h90);
    for (int k = 1; k <= 15; k++) begin
      cyc();
      if (k < 15 && (done_o || err_to_o)) early = 1'b1;
    end
    checks++;
    if (early !== 1'b0) begin
      errors++;
      $display("FAIL timeout_early got %b want 0", early);
    end
    checks++;
    if ({err_to_o, done_o} !== 2'b11) begin
      errors++;
      $display("FAIL timeout_fire got err=%b done=%b want 1 1", err_to_o, done_o);
    end
    cyc();
    checks++;
    if ({err_to_o, done_o, busy_o} !== 3'b100) begin
      errors++;
      $display("FAIL timeout_sticky got %b want 100", {err_to_o, done_o, busy_o});
    end
    start_i   = 1'b1;
    reuse_w_i = 1'b1;
    cyc();
    start_i   = 1'b0;
    reuse_w_i = 1'b0;
    checks++;
    if ({err_to_o, mac_data_rst_o} !== 2'b01) begin
      errors++;
      $display("FAIL timeout_clear got err=%b rst=%b want 0 1", err_to_o, mac_data_rst_o);
    end
    cyc();
    feed(4, 8'h31);
    results(4, 8'h40);
    checks++;
    if ({done_o, err_to_o} !== 2'b10) begin
      errors++;
      $display("FAIL timeout_next_job got done=%b err=%b want 1 0", done_o, err_to_o);
    end
    cyc();
    $display("timeout: err cleared by next start");
  endtask

  task automatic test_reset_mid();
    logic [23:0] v;
    int r0, w0, x0;
    begin_job(1'b0);
    feed(4, 8'h01);
    feed(2, 8'h05);
    rst_n = 1'b0;
    cyc();
    v = {in_rdy_o, mac_data_v_o, mac_data_mode_o, mac_data_rst_o, mac_data_o,
         out_v_o, out_data_o, busy_o, done_o, err_to_o};
    checks++;
    if (v !== 24'h0) begin
      errors++;
      $display("FAIL midreset_outputs got %h want 000000", v);
    end
    rst_n = 1'b1;
    cyc();
    r0 = n_rst; w0 = n_wbeat; x0 = n_xbeat;
    begin_job(1'b0);
    feed(8, 8'h61);
    results(4, 8'h71);
    checks++;
    if ({done_o, out_data_o, err_to_o} !== {1'b1, 8'h74, 1'b0}) begin
      errors++;
      $display("FAIL midreset_job got done=%b d=%h err=%b want 1 74 0",
               done_o, out_data_o, err_to_o);
    end
    cyc();
    checks++;
    if ({n_rst - r0, n_wbeat - w0, n_xbeat - x0} !== {32'd1, 32'd4, 32'd4}) begin
      errors++;
      $display("FAIL midreset_counts got rst=%0d w=%0d x=%0d want 1 4 4",
               n_rst - r0, n_wbeat - w0, n_xbeat - x0);
    end
    $display("reset_mid: follow-up job complete");
  endtask

  task automatic test_stall();
    int r0, w0, x0, d0;
    logic [12:0] got;
    r0 = n_rst; w0 = n_wbeat; x0 = n_xbeat; d0 = n_done;
    begin_job(1'b0);
    feed(2, 8'h01);
    ena       = 1'b0;
    in_v_i    = 1'b1;
    in_data_i = 8'h33;
    for (int s = 0; s < 5; s++) begin
      cyc();
      got = {in_rdy_o, mac_data_v_o, mac_data_mode_o, mac_data_o, busy_o, done_o};
      checks++;
      if (got !== {1'b0, 1'b1, 1'b1, 8'h02, 1'b1, 1'b0}) begin
        errors++;
        $display("FAIL stall_frozen%0d got %h want %h", s, got,
                 {1'b0, 1'b1, 1'b1, 8'h02, 1'b1, 1'b0});
      end
    end
    in_v_i = 1'b0;
    ena    = 1'b1;
    feed(2, 8'h03);
    feed(4, 8'h05);
    checks++;
    if ({in_rdy_o, busy_o} !== 2'b01) begin
      errors++;
      $display("FAIL stall_drain got rdy=%b busy=%b want 0 1", in_rdy_o, busy_o);
    end
    start_i = 1'b1;
    cyc();
    start_i = 1'b0;
    checks++;
    if ({mac_data_rst_o, busy_o} !== 2'b01) begin
      errors++;
      $display("FAIL stall_ignored_start got rst=%b busy=%b want 0 1", mac_data_rst_o, busy_o);
    end
    results(4, 8'h81);
    checks++;
    if (done_o !== 1'b1) begin
      errors++;
      $display("FAIL stall_done got %b want 1", done_o);
    end
    cyc();
    checks++;
    if ({n_rst - r0, n_wbeat - w0, n_xbeat - x0, n_done - d0} !== {32'd1, 32'd4, 32'd4, 32'd1}) begin
      errors++;
      $display("FAIL stall_counts got rst=%0d w=%0d x=%0d done=%0d want 1 4 4 1",
               n_rst - r0, n_wbeat - w0, n_xbeat - x0, n_done - d0);
    end
    $display("stall: rst=%0d w=%0d x=%0d", n_rst - r0, n_wbeat - w0, n_xbeat - x0);
  endtask

  initial begin
    test_reset();
    test_full_job();
    test_reuse();
    test_bubbles();
    test_timeout();
    test_reset_mid();
    test_stall();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
